// File: rtl/ahb_pkg.sv
// AHB-Lite encodings, the initiator pipeline stage record and control parity.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef struct packed {
    logic        valid;
    logic        cancel;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ahb_stage_t;

  function automatic logic ahb_ctrl_parity(
    input logic [2:0] hsize,
    input logic [2:0] hburst,
    input logic [3:0] hprot,
    input logic       hwrite,
    input logic       hmastlock
  );
    return (^hsize) ^ (^hburst) ^ (^hprot) ^ hwrite ^ hmastlock;
  endfunction

endpackage

// File: rtl/edac_pkg.sv
// EDAC helpers shared by the protected AHB-Lite slaves and their initiators.
// edac_checksum is a 32-bit SEC-DED code: six Hamming bits plus overall parity.
package edac_pkg;

  // Data bits occupy the non-power-of-two Hamming positions 3..38. Check bit j
  // covers every data bit whose position has bit j set.
  function automatic logic [6:0] edac_checksum(input logic [31:0] data);
    logic [6:0] chk;
    int         idx;
    chk = '0;
    idx = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int j = 0; j < 6; j++) begin
          if (p[j]) chk[j] = chk[j] ^ data[idx];
        end
        idx++;
      end
    end
    chk[6] = (^data) ^ (^chk[5:0]);
    return chk;
  endfunction

endpackage

// File: rtl/ahb_parity_gen.sv
// Combinational interface-protection generator: control parity and write-data
// checksum. All outputs are zero when protection is disabled.
module ahb_parity_gen
  import ahb_pkg::*;
  import edac_pkg::*;
#(
  parameter bit IFP = 1'b0
) (
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hwrite,
  input  logic        hmastlock,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [5:0]  hparity,
  output logic [6:0]  hwchecksum
);

  always_comb begin
    hparity    = '0;
    hwchecksum = '0;
    if (IFP) begin
      for (int k = 0; k < 4; k++) begin
        hparity[k] = ^haddr[8*k +: 8];
      end
      hparity[4] = ahb_ctrl_parity(hsize, hburst, hprot, hwrite, hmastlock);
      hparity[5] = ^htrans;
      hwchecksum = edac_checksum(hwdata);
    end
  end

endmodule

// File: rtl/ahb_initiator.sv
// AHB-Lite master: valid/ready requests become pipelined SINGLE transfers with
// one in-order response each. Handshake: a request transfers on the rising edge
// where req_valid_i and req_ready_o are both high; rsp_valid_o is a one-cycle
// strobe that cannot be back-pressured.
module ahb_initiator
  import ahb_pkg::*;
  import edac_pkg::*;
#(
  parameter bit IFP = 1'b0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_write_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_chk_o,
  output logic [31:0] m_haddr_o,
  output logic [31:0] m_hwdata_o,
  output logic [2:0]  m_hburst_o,
  output logic        m_hmastlock_o,
  output logic [3:0]  m_hprot_o,
  output logic [2:0]  m_hsize_o,
  output logic [1:0]  m_htrans_o,
  output logic        m_hwrite_o,
  output logic [5:0]  m_hparity_o,
  output logic [6:0]  m_hwchecksum_o,
  input  logic [31:0] m_hrdata_i,
  input  logic [6:0]  m_hrchecksum_i,
  input  logic        m_hready_i,
  input  logic        m_hresp_i
);

  ahb_stage_t  ap_q, ap_d;
  ahb_stage_t  dp_q, dp_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_chk_q, rsp_chk_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic first_err;
  logic accept;
  logic complete;
  logic rd_ok;

  always_comb begin
    first_err   = dp_q.valid & m_hresp_i & ~m_hready_i;
    req_ready_o = ~ap_q.valid | (m_hready_i & ~m_hresp_i);
    accept      = req_valid_i & req_ready_o;
    complete    = dp_q.valid & m_hready_i;
    rd_ok       = complete & ~dp_q.write & ~dp_q.cancel;

    // Address-phase stage: fields are kept when it empties so the bus holds
    // its last address/control while HTRANS shows IDLE.
    ap_d = ap_q;
    if (m_hready_i) ap_d.valid = 1'b0;
    if (first_err && ap_q.valid) ap_d.cancel = 1'b1;
    if (accept) begin
      ap_d.valid  = 1'b1;
      ap_d.cancel = 1'b0;
      ap_d.write  = req_write_i;
      ap_d.size   = req_size_i;
      ap_d.addr   = req_addr_i;
      ap_d.wdata  = req_wdata_i;
    end

    // A cancelled entry still walks through the data-phase stage so its error
    // response stays in request order.
    dp_d = dp_q;
    if (m_hready_i) begin
      dp_d.valid = 1'b0;
      if (ap_q.valid) dp_d = ap_q;
    end

    rsp_valid_d = complete;
    rsp_err_d   = complete & (dp_q.cancel | m_hresp_i);
    rsp_rdata_d = rd_ok ? m_hrdata_i : '0;
    rsp_chk_d   = IFP & rd_ok & (edac_checksum(m_hrdata_i) != m_hrchecksum_i);
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      ap_q        <= '0;
      dp_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_chk_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_q        <= ap_d;
      dp_q        <= dp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_chk_q   <= rsp_chk_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // The first error cycle must not start the pending transfer, even before
  // its cancel flag has been registered.
  assign m_htrans_o    = (ap_q.valid & ~ap_q.cancel & ~first_err) ? HTRANS_NONSEQ
                                                                   : HTRANS_IDLE;
  assign m_haddr_o     = ap_q.addr;
  assign m_hsize_o     = {1'b0, ap_q.size};
  assign m_hwrite_o    = ap_q.write;
  assign m_hwdata_o    = dp_q.wdata;
  assign m_hburst_o    = HBURST_SINGLE;
  assign m_hmastlock_o = 1'b0;
  assign m_hprot_o     = HPROT_DEFAULT;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_chk_o   = rsp_chk_q;
  assign rsp_rdata_o = rsp_rdata_q;

  ahb_parity_gen #(
    .IFP(IFP)
  ) u_parity (
    .haddr     (m_haddr_o),
    .hsize     (m_hsize_o),
    .hburst    (m_hburst_o),
    .hprot     (m_hprot_o),
    .hwrite    (m_hwrite_o),
    .hmastlock (m_hmastlock_o),
    .htrans    (m_htrans_o),
    .hwdata    (m_hwdata_o),
    .hparity   (m_hparity_o),
    .hwchecksum(m_hwchecksum_o)
  );

endmodule

// File: tb/tb_ahb_initiator.sv
// Bench for ahb_initiator: an unprotected and a protected instance share one
// stimulus stream and are compared every cycle against a request-queue model.
module tb_ahb_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;
  logic [6:0]  m_hrchecksum;

  logic        o0_ready, o0_rv, o0_err, o0_chk, o0_hwrite, o0_hmastlock;
  logic [31:0] o0_rdata, o0_haddr, o0_hwdata;
  logic [2:0]  o0_hburst, o0_hsize;
  logic [3:0]  o0_hprot;
  logic [1:0]  o0_htrans;
  logic [5:0]  o0_hparity;
  logic [6:0]  o0_hwcs;

  logic        o1_ready, o1_rv, o1_err, o1_chk, o1_hwrite, o1_hmastlock;
  logic [31:0] o1_rdata, o1_haddr, o1_hwdata;
  logic [2:0]  o1_hburst, o1_hsize;
  logic [3:0]  o1_hprot;
  logic [1:0]  o1_htrans;
  logic [5:0]  o1_hparity;
  logic [6:0]  o1_hwcs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_initiator #(.IFP(1'b0)) u_dut0 (
    .s_clk_i(clk), .s_resetn_i(resetn),
    .req_valid_i(req_valid), .req_ready_o(o0_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_size_i(req_size), .req_write_i(req_write),
    .rsp_valid_o(o0_rv), .rsp_rdata_o(o0_rdata), .rsp_err_o(o0_err), .rsp_chk_o(o0_chk),
    .m_haddr_o(o0_haddr), .m_hwdata_o(o0_hwdata), .m_hburst_o(o0_hburst),
    .m_hmastlock_o(o0_hmastlock), .m_hprot_o(o0_hprot), .m_hsize_o(o0_hsize),
    .m_htrans_o(o0_htrans), .m_hwrite_o(o0_hwrite), .m_hparity_o(o0_hparity),
    .m_hwchecksum_o(o0_hwcs), .m_hrdata_i(m_hrdata), .m_hrchecksum_i(m_hrchecksum),
    .m_hready_i(m_hready), .m_hresp_i(m_hresp)
  );

  ahb_initiator #(.IFP(1'b1)) u_dut1 (
    .s_clk_i(clk), .s_resetn_i(resetn),
    .req_valid_i(req_valid), .req_ready_o(o1_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_size_i(req_size), .req_write_i(req_write),
    .rsp_valid_o(o1_rv), .rsp_rdata_o(o1_rdata), .rsp_err_o(o1_err), .rsp_chk_o(o1_chk),
    .m_haddr_o(o1_haddr), .m_hwdata_o(o1_hwdata), .m_hburst_o(o1_hburst),
    .m_hmastlock_o(o1_hmastlock), .m_hprot_o(o1_hprot), .m_hsize_o(o1_hsize),
    .m_htrans_o(o1_htrans), .m_hwrite_o(o1_hwrite), .m_hparity_o(o1_hparity),
    .m_hwchecksum_o(o1_hwcs), .m_hrdata_i(m_hrdata), .m_hrchecksum_i(m_hrchecksum),
    .m_hready_i(m_hready), .m_hresp_i(m_hresp)
  );

  // SEC-DED reference: the six low bits are the XOR of the Hamming positions
  // of all set data bits; bit 6 is parity over data and those six bits.
  function automatic logic [6:0] ref_chk(input logic [31:0] d);
    logic [5:0] syn;
    int         pos;
    syn = '0;
    pos = 2;
    for (int i = 0; i < 32; i++) begin
      pos++;
      while ($countones(pos) == 1) pos++;
      if (d[i]) syn = syn ^ pos[5:0];
    end
    return {(^d) ^ (^syn), syn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        cancelled;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ent_t;

  ent_t        pipe_q[$];          // accepted, not yet completed, in order
  int          dp_cnt = 0;         // leading entries of pipe_q already past the address phase
  logic [33:0] exp_q[$];           // {err, chk, rdata} due next cycle
  logic [31:0] last_addr, last_wdata;
  logic [1:0]  last_size;
  logic        last_write;
  bit          seen_rst = 1'b0;

  logic        e_rdy, e_rv;
  logic [1:0]  e_htrans;
  logic [5:0]  e_par;
  logic [6:0]  e_wcs;
  logic [33:0] e_rsp;

  task automatic check_dut(input string t, input bit ifp, input logic rdy_a,
                           input logic [1:0] htrans_a, input logic [31:0] haddr_a,
                           input logic [31:0] hwdata_a, input logic [2:0] hsize_a,
                           input logic hwrite_a, input logic [2:0] hburst_a,
                           input logic hmastlock_a, input logic [3:0] hprot_a,
                           input logic [5:0] par_a, input logic [6:0] wcs_a,
                           input logic rv_a, input logic err_a, input logic chk_a,
                           input logic [31:0] rdata_a);
    chk({t, ".req_ready"}, 32'(rdy_a), 32'(e_rdy));
    chk({t, ".htrans"}, 32'(htrans_a), 32'(e_htrans));
    chk({t, ".haddr"}, haddr_a, last_addr);
    chk({t, ".hwdata"}, hwdata_a, last_wdata);
    chk({t, ".hsize"}, 32'(hsize_a), 32'({1'b0, last_size}));
    chk({t, ".hwrite"}, 32'(hwrite_a), 32'(last_write));
    chk({t, ".hburst"}, 32'(hburst_a), 32'd0);
    chk({t, ".hmastlock"}, 32'(hmastlock_a), 32'd0);
    chk({t, ".hprot"}, 32'(hprot_a), 32'd3);
    chk({t, ".hparity"}, 32'(par_a), ifp ? 32'(e_par) : 32'd0);
    chk({t, ".hwchecksum"}, 32'(wcs_a), ifp ? 32'(e_wcs) : 32'd0);
    chk({t, ".rsp_valid"}, 32'(rv_a), 32'(e_rv));
    if (e_rv) begin
      chk({t, ".rsp_err"}, 32'(err_a), 32'(e_rsp[33]));
      chk({t, ".rsp_chk"}, 32'(chk_a), ifp ? 32'(e_rsp[32]) : 32'd0);
      chk({t, ".rsp_rdata"}, rdata_a, e_rsp[31:0]);
    end
  endtask

  // Inputs only change just after rising edges, so evaluating at the falling
  // edge both checks this cycle and predicts the coming edge.
  always @(negedge clk) begin : model
    int          ap_pend;
    logic        ferr, rdy, rd, bad;
    ent_t        ap_e, d_e;
    logic [3:0]  prot_c;
    ap_pend = pipe_q.size() - dp_cnt;
    ferr    = (dp_cnt != 0) && m_hresp && !m_hready;
    rdy     = (ap_pend == 0) || (m_hready && !m_hresp);
    ap_e    = '0;
    if (ap_pend != 0) ap_e = pipe_q[dp_cnt];
    prot_c  = 4'b0011;

    e_rdy    = rdy;
    e_htrans = (ap_pend != 0 && !ap_e.cancelled && !ferr) ? 2'b10 : 2'b00;
    for (int k = 0; k < 4; k++) e_par[k] = ^last_addr[8*k +: 8];
    e_par[4] = (^last_size) ^ (^prot_c) ^ last_write;
    e_par[5] = ^e_htrans;
    e_wcs    = ref_chk(last_wdata);
    e_rv     = (exp_q.size() != 0);
    e_rsp    = e_rv ? exp_q[0] : '0;

    if (seen_rst) begin
      check_dut("ifp0", 1'b0, o0_ready, o0_htrans, o0_haddr, o0_hwdata, o0_hsize, o0_hwrite,
                o0_hburst, o0_hmastlock, o0_hprot, o0_hparity, o0_hwcs, o0_rv, o0_err,
                o0_chk, o0_rdata);
      check_dut("ifp1", 1'b1, o1_ready, o1_htrans, o1_haddr, o1_hwdata, o1_hsize, o1_hwrite,
                o1_hburst, o1_hmastlock, o1_hprot, o1_hparity, o1_hwcs, o1_rv, o1_err,
                o1_chk, o1_rdata);
    end
    if (e_rv) void'(exp_q.pop_front());

    if (!resetn) begin
      pipe_q.delete();
      exp_q.delete();
      dp_cnt     = 0;
      last_addr  = '0;
      last_wdata = '0;
      last_size  = '0;
      last_write = 1'b0;
      seen_rst   = 1'b1;
    end else begin
      if (m_hready) begin
        if (dp_cnt != 0) begin
          d_e = pipe_q.pop_front();
          rd  = !d_e.write && !d_e.cancelled;
          bad = rd && (ref_chk(m_hrdata) != m_hrchecksum);
          exp_q.push_back({d_e.cancelled | m_hresp, bad, rd ? m_hrdata : 32'h0});
          dp_cnt = 0;
        end
        if (ap_pend != 0) begin
          dp_cnt     = 1;
          last_wdata = ap_e.wdata;
        end
      end else if (ferr && ap_pend != 0) begin
        ap_e.cancelled = 1'b1;
        pipe_q[dp_cnt] = ap_e;
      end
      if (req_valid && rdy) begin
        pipe_q.push_back({1'b0, req_write, req_size, req_addr, req_wdata});
        last_addr  = req_addr;
        last_size  = req_size;
        last_write = req_write;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit rdy, input bit rsp,
                       input logic [31:0] rdat, input logic [6:0] flip);
    req_valid    = v;
    req_write    = w;
    req_addr     = a;
    req_wdata    = wd;
    req_size     = sz;
    m_hready     = rdy;
    m_hresp      = rsp;
    m_hrdata     = rdat;
    m_hrchecksum = ref_chk(rdat) ^ flip;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0, 7'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    resetn = 1'b0;
    idle_in();
    repeat (2) step();
    settle();
    chk("reset.htrans", 32'(o1_htrans), 32'd0);
    chk("reset.haddr", o1_haddr, 32'h0);
    chk("reset.hwdata", o1_hwdata, 32'h0);
    chk("reset.rsp_valid", 32'(o1_rv), 32'd0);
    resetn = 1'b1;
    step();
    settle();
    chk("reset.req_ready", 32'(o1_ready), 32'd1);

    // Zero-wait word write.
    step();
    drive(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    idle_in(); settle();
    chk("wr.htrans_c1", 32'(o1_htrans), 32'd2);
    chk("wr.haddr_c1", o1_haddr, 32'h8);
    step(); settle();
    chk("wr.hwdata_c2", o1_hwdata, 32'hDEADBEEF);
    step(); settle();
    chk("wr.rsp_valid_c3", 32'(o1_rv), 32'd1);
    chk("wr.rsp_err_c3", 32'(o1_err), 32'd0);
    step();

    // Back-to-back reads.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); settle();
    chk("b2b.ready0", 32'(o1_ready), 32'd1); step();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); settle();
    chk("b2b.ready1", 32'(o1_ready), 32'd1); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h11, 7'h0); settle();
    chk("b2b.haddr2", o1_haddr, 32'h4); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h22, 7'h0); settle();
    chk("b2b.rdata0", o1_rdata, 32'h11); step();
    idle_in(); settle();
    chk("b2b.rdata1", o1_rdata, 32'h22); step();

    // Read with three wait states, a second read queued in the address phase.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    drive(1'b1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 7'h0);
    for (int w = 0; w < 3; w++) begin
      settle();
      chk("wait.req_ready", 32'(o1_ready), 32'd0);
      chk("wait.haddr", o1_haddr, 32'h14);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h33, 7'h0); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h44, 7'h0); settle();
    chk("wait.rdata0", o1_rdata, 32'h33); step();
    idle_in(); settle();
    chk("wait.rdata1", o1_rdata, 32'h44); step();

    // Errored write cancels the following read.
    drive(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    drive(1'b1, 1'b0, 32'h24, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0, 7'h0); settle();
    chk("err.htrans_e1", 32'(o1_htrans), 32'd0); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 32'h0, 7'h0); settle();
    chk("err.htrans_e2", 32'(o1_htrans), 32'd0); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 7'h0); settle();
    chk("err.wr_err", 32'(o1_err), 32'd1);
    chk("err.htrans_c4", 32'(o1_htrans), 32'd0); step();
    idle_in(); settle();
    chk("err.rd_err", 32'(o1_err), 32'd1);
    chk("err.rd_rdata", o1_rdata, 32'h0); step();

    // Read checksum off by one bit.
    drive(1'b1, 1'b0, 32'h30, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    idle_in(); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h12345678, 7'h01); step();
    idle_in(); settle();
    chk("ifp.rsp_chk", 32'(o1_chk), 32'd1);
    chk("ifp.rsp_err", 32'(o1_err), 32'd0);
    chk("ifp0.rsp_chk", 32'(o0_chk), 32'd0); step();

    // Address parity of 0x103.
    drive(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0, 7'h0); step();
    idle_in(); settle();
    chk("par.bit0", 32'(o1_hparity[0]), 32'd0);
    chk("par.bit1", 32'(o1_hparity[1]), 32'd1);
    chk("par.ifp0", 32'(o0_hparity), 32'd0);
    repeat (3) step();

    // Reset during a data phase, then a fresh read.
    drive(1'b1, 1'b1, 32'h40, 32'h77, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); step();
    idle_in(); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0, 7'h0);
    resetn = 1'b0; step();
    resetn = 1'b1;
    drive(1'b1, 1'b0, 32'h50, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0, 7'h0); settle();
    chk("rst.htrans", 32'(o1_htrans), 32'd0);
    chk("rst.rsp_valid", 32'(o1_rv), 32'd0); step();
    idle_in(); settle();
    chk("rst.haddr", o1_haddr, 32'h50); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h99, 7'h0); step();
    idle_in(); settle();
    chk("rst.rsp_valid2", 32'(o1_rv), 32'd1);
    chk("rst.rdata", o1_rdata, 32'h99);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
